// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Drives the select of a 4:1 multiplexer through channels 0..3.
//   Each channel is held for SETTLE cycles, and then the multiplexer output y
//   is sampled. After channel 3 the four samples are presented as one frame
//   with a one-cycle valid strobe. Supports single-shot and continuous
//   scanning, and a synchronous abort.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a scan (honoured only in IDLE)
//   cont       continuous mode, examined at each frame end
//   abort      synchronous abort back to IDLE
//   y          multiplexer output for the current select
//   s          multiplexer select (registered)
//   busy       high while scanning
//   data       last completed frame, data[k] = y sampled with s == k
//   valid      one-cycle strobe following a data update
//   frame_cnt  completed-frame counter, wraps 255 -> 0
//
// State table
//   state | meaning
//   IDLE  | select parked at 0, waiting for start
//   SCAN  | stepping channels, settle counter running

module mux_scan_sequencer #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       abort,
    input  logic       y,
    output logic [1:0] s,
    output logic       busy,
    output logic [3:0] data,
    output logic       valid,
    output logic [7:0] frame_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [2:0] shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s         <= 2'd0;
            busy      <= 1'b0;
            data      <= 4'd0;
            valid     <= 1'b0;
            frame_cnt <= 8'd0;
            cnt       <= 8'd0;
            shadow    <= 3'd0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    s   <= 2'd0;
                    cnt <= 8'd0;
                    if (start) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        s     <= 2'd0;
                        cnt   <= 8'd0;
                    end else if (cnt != SETTLE_M1) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        cnt <= 8'd0;
                        if (s != 2'd3) begin
                            shadow[s] <= y;
                            s         <= s + 2'd1;
                        end else begin
                            // channel 3 goes straight into the frame; no need to shadow it
                            data      <= {y, shadow};
                            valid     <= 1'b1;
                            frame_cnt <= frame_cnt + 8'd1;
                            s         <= 2'd0;
                            if (!cont) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer
//   Directed bench for mux_scan_sequencer. Two instances: dut_a with
//   SETTLE=2 and dut_b with SETTLE=1. Each multiplexer is modelled as
//   y = mux_in[s].

module tb_mux_scan_sequencer;

    logic       clk;
    logic       rst_n;

    logic       start_a, cont_a, abort_a, y_a;
    logic [1:0] s_a;
    logic       busy_a, valid_a;
    logic [3:0] data_a;
    logic [7:0] frame_cnt_a;
    logic [3:0] mux_a;

    logic       start_b, cont_b, abort_b, y_b;
    logic [1:0] s_b;
    logic       busy_b, valid_b;
    logic [3:0] data_b;
    logic [7:0] frame_cnt_b;
    logic [3:0] mux_b;

    int n_tests = 0;
    int n_fail  = 0;

    assign y_a = mux_a[s_a];
    assign y_b = mux_b[s_b];

    mux_scan_sequencer #(.SETTLE(2)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_a),
        .cont      (cont_a),
        .abort     (abort_a),
        .y         (y_a),
        .s         (s_a),
        .busy      (busy_a),
        .data      (data_a),
        .valid     (valid_a),
        .frame_cnt (frame_cnt_a)
    );

    mux_scan_sequencer #(.SETTLE(1)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_b),
        .cont      (cont_b),
        .abort     (abort_b),
        .y         (y_b),
        .s         (s_b),
        .busy      (busy_b),
        .data      (data_b),
        .valid     (valid_b),
        .frame_cnt (frame_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // called just after an edge; reset pulse ends before the next falling edge
    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        int pulses;
        int nvalid;
        int last_i;

        rst_n   = 1'b0;
        start_a = 1'b0; cont_a = 1'b0; abort_a = 1'b0; mux_a = 4'b0000;
        start_b = 1'b0; cont_b = 1'b0; abort_b = 1'b0; mux_b = 4'b0000;
        #23;
        chk("rst_s",     32'(s_a), 32'd0);
        chk("rst_busy",  32'(busy_a), 32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_data",  32'(data_a), 32'd0);
        chk("rst_fcnt",  32'(frame_cnt_a), 32'd0);
        rst_n = 1'b1;
        tick();

        // single shot, ch0 high
        mux_a   = 4'b0001;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("a_s_seq", 32'(s_a), 32'(i / 2));
            chk("a_busy",  32'(busy_a), 32'd1);
            chk("a_novalid", 32'(valid_a), 32'd0);
            tick();
        end
        chk("a_valid", 32'(valid_a), 32'd1);
        chk("a_data",  32'(data_a), 32'b0001);
        chk("a_fcnt",  32'(frame_cnt_a), 32'd1);
        chk("a_busy_fall", 32'(busy_a), 32'd0);
        tick();
        chk("a_valid_one", 32'(valid_a), 32'd0);

        // continuous, three frames
        do_reset();
        tick();
        mux_a   = 4'b0110;
        cont_a  = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        pulses  = 0;
        for (int i = 1; i <= 34; i++) begin
            tick();
            if (valid_a) begin
                pulses++;
                chk("b_valid_cycle", 32'(i), 32'(8 * pulses));
                chk("b_data", 32'(data_a), 32'b0110);
                if (pulses == 2) cont_a = 1'b0;
            end
        end
        chk("b_pulses", 32'(pulses), 32'd3);
        chk("b_idle",   32'(busy_a), 32'd0);
        chk("b_fcnt",   32'(frame_cnt_a), 32'd3);

        // abort at cycle 5
        mux_a   = 4'b1111;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("c_busy",  32'(busy_a), 32'd0);
        chk("c_s",     32'(s_a), 32'd0);
        chk("c_valid", 32'(valid_a), 32'd0);
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid_a) nvalid++;
        end
        chk("c_novalid", 32'(nvalid), 32'd0);
        chk("c_data",    32'(data_a), 32'b0110);
        chk("c_fcnt",    32'(frame_cnt_a), 32'd3);

        // asynchronous reset mid-frame
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("d_pre_s", 32'(s_a), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("d_s",     32'(s_a), 32'd0);
        chk("d_busy",  32'(busy_a), 32'd0);
        chk("d_data",  32'(data_a), 32'd0);
        chk("d_fcnt",  32'(frame_cnt_a), 32'd0);
        chk("d_valid", 32'(valid_a), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        mux_a   = 4'b1010;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        nvalid = 0;
        last_i = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (valid_a) begin
                nvalid++;
                last_i = i;
            end
        end
        chk("d2_nvalid", 32'(nvalid), 32'd1);
        chk("d2_cycle",  32'(last_i), 32'd8);
        chk("d2_data",   32'(data_a), 32'b1010);
        chk("d2_fcnt",   32'(frame_cnt_a), 32'd1);

        // start pulses during SCAN are ignored
        mux_a   = 4'b0101;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        nvalid = 0;
        last_i = 0;
        for (int i = 1; i <= 20; i++) begin
            start_a = (i <= 7) ? 1'(i % 2) : 1'b0;
            tick();
            if (valid_a) begin
                nvalid++;
                last_i = i;
            end
        end
        start_a = 1'b0;
        chk("e_nvalid", 32'(nvalid), 32'd1);
        chk("e_cycle",  32'(last_i), 32'd8);
        chk("e_data",   32'(data_a), 32'b0101);
        chk("e_fcnt",   32'(frame_cnt_a), 32'd2);
        chk("e_idle",   32'(busy_a), 32'd0);

        // SETTLE=1, 256 continuous frames, counter wrap
        mux_b   = 4'b1001;
        cont_b  = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        pulses  = 0;
        nvalid  = 0;
        for (int i = 1; i <= 1030; i++) begin
            tick();
            if (valid_b) begin
                pulses++;
                if (i != 4 * pulses || data_b !== 4'b1001) nvalid++;
                if (pulses == 255) begin
                    chk("f_fcnt255", 32'(frame_cnt_b), 32'd255);
                    cont_b = 1'b0;
                end
                if (pulses == 256) chk("f_fcnt_wrap", 32'(frame_cnt_b), 32'd0);
            end
        end
        chk("f_bad_frames", 32'(nvalid), 32'd0);
        chk("f_pulses",     32'(pulses), 32'd256);
        chk("f_idle",       32'(busy_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Control stage that sits directly upstream of the gate-level 4:1 multiplexer (`multiplexer4to1`). It drives the 2-bit select, steps it through channels 0..3, and waits a programmable settle time on each channel. It then samples the multiplexer output `y` and presents the four sampled bits as one parallel frame with a one-cycle valid strobe. It supports single-shot and continuous scanning, with abort.

## Interface
- `SETTLE`, default 2: cycles each channel is held before `y` is sampled; legal range 1..255.
- `clk`  input  1  system clock; all state changes on rising edge.
- `rst_n`  input  1  reset; one clock; reset is asynchronous and active-low.
- `start`  input  1  begin a scan; honoured only in IDLE.
- `cont`  input  1  continuous mode; sampled at the end of each frame.
- `abort`  input  1  synchronous abort; returns to IDLE.
- `y`  input  1  multiplexer output, assumed combinationally dependent on `s`.
- `s`  output  2  multiplexer select, registered.
- `busy`  output  1  high in SCAN state.
- `data`  output  4  last completed frame; `data[k]` = `y` sampled while `s == k`.
- `valid`  output  1  one-cycle strobe, high in the cycle after `data` updates.
- `frame_cnt`  output  8  completed-frame counter; wraps 255 -> 0.

## Operation
- Reset (async, `rst_n` low): state IDLE, `s`=0, `busy`=0, `valid`=0, `data`=0, `frame_cnt`=0, settle counter=0, shadow=0. Takes effect immediately, mid-scan included; no partial frame is emitted.
- States: IDLE and SCAN. `busy` = (state == SCAN), registered.
- IDLE:
  - `s` held at 0.
  - `start`=1 at an edge -> SCAN, `s`=0, counter=0.
  - `start` pulse width is irrelevant; the level is sampled at the edge.
- SCAN, each edge:
  - If `abort`=1 -> IDLE, `s`=0, counter=0. `data`, `frame_cnt` unchanged, no `valid`. Abort has priority over every other SCAN action.
  - Else if counter < SETTLE-1 -> counter+1.
  - Else (counter == SETTLE-1) -> capture `y` into shadow bit `s`, then counter=0.
    - If `s` < 3: `s`+1.
    - If `s` == 3: `data` = {y, shadow[2:0]}, `valid` asserted next cycle, `frame_cnt`+1 mod 256, `s`=0. Stay in SCAN if `cont`=1, else go to IDLE.
- `start` while in SCAN: ignored, no restart.
- `valid` is high for exactly one cycle per completed frame and is otherwise 0.
- `cont` is examined only at the frame-end edge; clearing it mid-frame finishes the current frame.
- SETTLE=1: one channel per cycle, sample taken at the edge after `s` changes.

## Timing
- Edge E0 samples `start`=1. Channel k is sampled at edge E0+(k+1)*SETTLE.
- `data`/`valid` update at edge E0+4*SETTLE; `valid` is high for the following cycle.
- Frame period in continuous mode: exactly 4*SETTLE cycles, no gap cycle.
- `s` changes only on edges; it is stable for SETTLE full cycles before each sample edge.
- Back-to-back single shots: `start` at the edge after a frame end (IDLE) begins the next frame. Minimum spacing is 4*SETTLE+1 cycles.

## Test plan
- SETTLE=2, mux inputs j,k,l,m = 1,0,0,0, pulse `start` -> `s` sequence 0,0,1,1,2,2,3,3; `valid` for one cycle 8 cycles after start edge; `data`=4'b0001; `frame_cnt`=1; `busy` falls with `valid`.
- j,k,l,m = 0,1,1,0, `cont`=1 for 3 frames then 0 -> three `valid` pulses exactly 8 cycles apart, each `data`=4'b0110; returns to IDLE after the 3rd frame; `frame_cnt`=3.
- Raise `abort` at cycle 5 of a frame -> next edge IDLE, `s`=0, `busy`=0; no `valid`; `data` and `frame_cnt` keep their prior values.
- Assert `rst_n` low asynchronously mid-frame, between edges -> all outputs 0 immediately. After release, `start` produces a clean full frame.
- Pulse `start` repeatedly during SCAN -> ignored; exactly one frame, timing unchanged.
- SETTLE=1, `cont`=1, run 256 frames -> `valid` every 4 cycles; `frame_cnt` wraps to 0 on the 256th frame.
